// File: rtl/biriscv_trace_seq_if.sv
// Retire/trace handshake bundle: two retire slots in, one serialised trace port out.
interface biriscv_trace_seq_if;
    logic        pipe0_valid_i;
    logic [31:0] pipe0_pc_i;
    logic [31:0] pipe0_opcode_i;
    logic        pipe1_valid_i;
    logic [31:0] pipe1_pc_i;
    logic [31:0] pipe1_opcode_i;
    logic        trace_valid_o;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_opcode_o;
    logic        trace_accept_i;

    modport master (
        output pipe0_valid_i, pipe0_pc_i, pipe0_opcode_i,
        output pipe1_valid_i, pipe1_pc_i, pipe1_opcode_i,
        output trace_accept_i,
        input  trace_valid_o, trace_pc_o, trace_opcode_o
    );

    modport slave (
        input  pipe0_valid_i, pipe0_pc_i, pipe0_opcode_i,
        input  pipe1_valid_i, pipe1_pc_i, pipe1_opcode_i,
        input  trace_accept_i,
        output trace_valid_o, trace_pc_o, trace_opcode_o
    );
endinterface

// File: rtl/biriscv_trace_seq.sv
// Retire-trace sequencer: buffers up to two retirements per cycle in program
// order and replays them one per cycle on a show-ahead trace port.
module biriscv_trace_seq #(
    parameter int DEPTH       = 8,
    parameter int DEPTH_W     = 3,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               clear_i,
    biriscv_trace_seq_if.slave trace_if,
    output logic [DEPTH_W:0]   level_o,
    output logic               overflow_o,
    output logic [15:0]        drop_count_o
);
    localparam int LW = DEPTH_W + 1;

    typedef enum logic {RUN, STOPPED} state_t;

    state_t             state, state_nxt;
    logic [31:0]        pc_mem [DEPTH];
    logic [31:0]        op_mem [DEPTH];
    logic [DEPTH_W-1:0] rd_ptr, wr_ptr, wr_ptr_p1;
    logic [LW-1:0]      level, free;
    logic [1:0]         n_req, n_acc, n_drop;
    logic               capture, pop;
    logic [31:0]        first_pc, first_op;
    logic [16:0]        drop_sum;

    always_comb begin
        state_nxt = state;
        n_acc     = '0;
        n_drop    = '0;
        n_req     = {1'b0, trace_if.pipe0_valid_i} + {1'b0, trace_if.pipe1_valid_i};
        // Room is judged on the registered level; a same-cycle pop frees nothing.
        free      = LW'(DEPTH) - level;
        capture   = enable_i && (state == RUN) && !clear_i;
        if (capture) begin
            if (LW'(n_req) <= free)
                n_acc = n_req;
            else
                n_acc = free[1:0];
            n_drop = n_req - n_acc;
        end
        pop = (level != '0) && trace_if.trace_accept_i && !clear_i;
        if (clear_i)
            state_nxt = RUN;
        else if (STOP_ON_OVF && (n_drop != '0))
            state_nxt = STOPPED;
        drop_sum  = {1'b0, drop_count_o} + 17'(n_drop);
        // Older valid slot goes first; pipe1 alone takes the first slot.
        first_pc  = trace_if.pipe0_valid_i ? trace_if.pipe0_pc_i     : trace_if.pipe1_pc_i;
        first_op  = trace_if.pipe0_valid_i ? trace_if.pipe0_opcode_i : trace_if.pipe1_opcode_i;
        wr_ptr_p1 = wr_ptr + DEPTH_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= RUN;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_i) begin
            state        <= RUN;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + DEPTH_W'(n_acc);
            rd_ptr <= rd_ptr + DEPTH_W'(pop);
            level  <= level + LW'(n_acc) - LW'(pop);
            if (n_drop != '0) begin
                overflow_o   <= 1'b1;
                drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk_i) begin
        if (n_acc != '0) begin
            pc_mem[wr_ptr] <= first_pc;
            op_mem[wr_ptr] <= first_op;
        end
        if (n_acc == 2'd2) begin
            pc_mem[wr_ptr_p1] <= trace_if.pipe1_pc_i;
            op_mem[wr_ptr_p1] <= trace_if.pipe1_opcode_i;
        end
    end

    assign level_o                 = level;
    assign trace_if.trace_valid_o  = (level != '0);
    assign trace_if.trace_pc_o     = (level != '0) ? pc_mem[rd_ptr] : '0;
    assign trace_if.trace_opcode_o = (level != '0) ? op_mem[rd_ptr] : '0;
endmodule

// File: doc/biriscv_trace_seq.md
Name: biriscv_trace_seq

Overview:
- Retire-trace sequencer for the dual-issue core.
- Takes up to two retired instructions per cycle (pipe0, pipe1), buffers them in program order, and serialises them one per cycle onto a single valid/pc/opcode trace port for the trace decoder/logger.
- Handles downstream backpressure, overflow accounting and an optional stop-on-overflow mode.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DEPTH_W, 3, log2(DEPTH).
- STOP_ON_OVF, 1, 1 = stop capturing after the first drop until clear_i; 0 = keep capturing, counting drops.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-low
- enable_i  input  1  capture enable; 0 = no pushes (draining continues)
- clear_i  input  1  synchronous flush of FIFO, statistics and FSM
- pipe0_valid_i  input  1  pipe0 retired an instruction (older slot)
- pipe0_pc_i  input  32  pipe0 PC
- pipe0_opcode_i  input  32  pipe0 opcode
- pipe1_valid_i  input  1  pipe1 retired an instruction (younger slot)
- pipe1_pc_i  input  32  pipe1 PC
- pipe1_opcode_i  input  32  pipe1 opcode
- trace_valid_o  output  1  head entry valid
- trace_pc_o  output  32  head PC
- trace_opcode_o  output  32  head opcode
- trace_accept_i  input  1  consumer takes head this cycle
- level_o  output  DEPTH_W+1  current occupancy
- overflow_o  output  1  sticky: at least one entry dropped
- drop_count_o  output  16  dropped entries, saturating at 0xFFFF

Behaviour:
- Reset (rst_i low, async): FIFO empty, rd/wr pointers 0, level_o=0, trace_valid_o=0, trace_pc_o=0, trace_opcode_o=0, overflow_o=0, drop_count_o=0, FSM=RUN.
- FIFO is show-ahead. trace_valid_o = (level != 0). trace_pc_o/trace_opcode_o come from the head entry and read 0 when empty.
- Pop occurs when trace_valid_o && trace_accept_i. The head advances next cycle.
- Push request set:
  - Both valid: pipe0 is written first, then pipe1 at wr_ptr+1.
  - Only pipe1 valid: pipe1 alone is written at wr_ptr.
  - Pushes happen only when enable_i=1 and FSM=RUN.
- Free space = DEPTH - level, taken from the registered level. A same-cycle pop does not create room.
- Partial fit: with 1 free slot and 2 requests, pipe0 is stored and pipe1 is dropped.
- Drop handling: each dropped entry increments drop_count_o (saturating) and sets overflow_o.
- Next level = level + pushes_accepted - pop. Pointers wrap modulo DEPTH.
- Latency: an entry pushed in cycle N is visible on the trace port in cycle N+1 (when it becomes head).
- FSM states:
  - RUN: capture active. Any drop with STOP_ON_OVF=1 -> STOPPED, taking effect next cycle. Entries accepted in the drop cycle are kept.
  - STOPPED: no pushes; all requests are ignored and not counted as drops; draining continues. clear_i -> RUN.
- clear_i takes priority over push and pop in the same cycle. Next cycle: level=0, pointers=0, overflow_o=0, drop_count_o=0, FSM=RUN. Requests in the clear cycle are discarded and not counted.
- enable_i=0: requests are ignored, not counted as drops.
- Reset mid-operation: all state returns to the reset values immediately; no partial entries survive.
- Full FIFO with pop and 2 requests in the same cycle: both requests are dropped, the pop proceeds, and level becomes DEPTH-1.

Test Plan:
- Single issue: pipe0 pc=0x80000000 op=0x00000013, accept held 1 -> trace_valid_o=1 next cycle with the same pc/op; level_o returns to 0 the cycle after.
- Dual issue: pipe0 pc=0x100 op=0x00A00093 plus pipe1 pc=0x104 op=0x00B00113 in one cycle, accept=1 -> trace output 0x100 then 0x104 on consecutive cycles; level_o sequence 2,1,0.
- Backpressure/fill: accept=0, 4 dual-issue cycles with DEPTH=8 -> level_o=8, no drops. A 5th dual cycle -> both dropped, drop_count_o=2, overflow_o=1.
- Partial fit: level=7, dual issue pc 0x200/0x204 -> 0x200 stored, level=8, drop_count_o=1. With STOP_ON_OVF=1, further pushes are ignored while accept=1 drains all 8 in order.
- Clear priority: in STOPPED with level=5, assert clear_i with a dual-issue request in the same cycle -> next cycle level_o=0, overflow_o=0, drop_count_o=0, FSM=RUN, and a subsequent push is accepted.
- Async reset: assert rst_i low mid-cycle with level=3 -> outputs zero immediately without a clock edge; after release, the first push appears at the output one cycle later.
